// File: rtl/me_msg.sv
`default_nettype none
// ============================================================================
// Package     : me_msg
// Description : Message formats shared by the memory engine and its clients.
// Revision    : 1.0 - initial release
// ============================================================================
package me_msg;

   localparam int ME_ADDR_W = 7;
   localparam int ME_DATA_W = 32;
   localparam int ME_LEN_W  = 8;

   localparam logic ME_TYPE_READ  = 1'b0;
   localparam logic ME_TYPE_WRITE = 1'b1;

   typedef struct packed {
      logic                 msg_type;
      logic [ME_ADDR_W-1:0] addr;
      logic [ME_DATA_W-1:0] data;
   } memory_engine_recv_msg;

   typedef struct packed {
      logic                 msg_type;
      logic [ME_DATA_W-1:0] data;
   } memory_engine_send_msg;

   typedef struct packed {
      logic                 is_write;
      logic [ME_ADDR_W-1:0] base_addr;
      logic [ME_LEN_W-1:0]  len;
   } me_job_msg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } me_state_e;

endpackage
`default_nettype wire

// File: rtl/me_stream_client_if.sv
`default_nettype none
// ============================================================================
// Interface   : me_stream_client_if
// Description : Job, write-data, read-data, engine and completion channels.
//               slave = the stream client, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface me_stream_client_if;
   import me_msg::*;

   logic                  job_val;
   logic                  job_rdy;
   me_job_msg             job_msg;
   logic                  wdata_val;
   logic                  wdata_rdy;
   logic [ME_DATA_W-1:0]  wdata_msg;
   logic                  rdata_val;
   logic                  rdata_rdy;
   logic [ME_DATA_W-1:0]  rdata_msg;
   logic                  mreq_val;
   logic                  mreq_rdy;
   memory_engine_recv_msg mreq_msg;
   logic                  mresp_val;
   logic                  mresp_rdy;
   memory_engine_send_msg mresp_msg;
   logic                  done_val;
   logic                  done_rdy;
   logic                  err;

   modport slave (
      input  job_val, job_msg, wdata_val, wdata_msg, rdata_rdy,
             mreq_rdy, mresp_val, mresp_msg, done_rdy,
      output job_rdy, wdata_rdy, rdata_val, rdata_msg, mreq_val,
             mreq_msg, mresp_rdy, done_val, err
   );

   modport master (
      output job_val, job_msg, wdata_val, wdata_msg, rdata_rdy,
             mreq_rdy, mresp_val, mresp_msg, done_rdy,
      input  job_rdy, wdata_rdy, rdata_val, rdata_msg, mreq_val,
             mreq_msg, mresp_rdy, done_val, err
   );

endinterface
`default_nettype wire

// File: rtl/me_resp_queue.sv
`default_nettype none
// ============================================================================
// Module      : me_resp_queue
// Description : Val/rdy FIFO for read responses with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module me_resp_queue #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
)(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_enq_val,
   output logic                         o_enq_rdy,
   input  logic [DATA_W-1:0]            i_enq_msg,
   output logic                         o_deq_val,
   input  logic                         i_deq_rdy,
   output logic [DATA_W-1:0]            o_deq_msg,
   output logic [$clog2(DEPTH):0]       o_count
);

   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_PTR_W-1:0] c_PTR_ONE = 1;
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = 1;
   localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);

   logic [DATA_W-1:0]  r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               w_enq;
   logic               w_deq;

   // A full queue still takes a word when the head leaves in the same cycle.
   assign o_enq_rdy = (r_count != c_FULL) || i_deq_rdy;
   assign o_deq_val = (r_count != '0);
   assign o_deq_msg = r_mem[r_rd_ptr];
   assign o_count   = r_count;
   assign w_enq     = i_enq_val && o_enq_rdy;
   assign w_deq     = o_deq_val && i_deq_rdy;

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_mem[r_wr_ptr] <= i_enq_msg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_deq) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_enq && !w_deq) begin
            r_count <= r_count + c_CNT_ONE;
         end else if (!w_enq && w_deq) begin
            r_count <= r_count - c_CNT_ONE;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/me_stream_client.sv
`default_nettype none
// ============================================================================
// Module      : me_stream_client
// Description : Turns read/write jobs into per-word memory-engine requests
//               and streams read responses back out in order.
// Revision    : 1.0 - initial release
// ============================================================================
module me_stream_client
   import me_msg::*;
#(
   parameter int ADDR_W          = ME_ADDR_W,
   parameter int DATA_W          = ME_DATA_W,
   parameter int LEN_W           = ME_LEN_W,
   parameter int MAX_OUTSTANDING = 4
)(
   input  logic              clk,
   input  logic              reset,
   me_stream_client_if.slave bus
);

   localparam int c_CNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [LEN_W:0] c_ONE   = 1;
   localparam logic [LEN_W:0] c_LIMIT = (LEN_W+1)'(MAX_OUTSTANDING);

   me_state_e          r_state;
   logic               r_is_write;
   logic [ADDR_W-1:0]  r_base;
   logic [LEN_W:0]     r_len;
   logic [LEN_W:0]     r_issued;
   logic [LEN_W:0]     r_received;
   logic               r_err;

   logic [c_CNT_W-1:0] w_fifo_count;
   logic               w_enq_val;
   logic               w_enq_rdy;
   logic               w_run;
   logic               w_credit;
   logic               w_mreq_val;
   logic               w_mreq_fire;
   logic               w_resp_active;
   logic               w_resp_count;
   logic [LEN_W:0]     w_inflight;
   logic [ADDR_W-1:0]  w_addr;

   assign w_run = (r_state == ST_RUN);

   // Buffered read words hold credit until consumed, so the queue never overflows.
   assign w_inflight  = (r_issued - r_received) + (LEN_W+1)'(w_fifo_count);
   assign w_credit    = (w_inflight < c_LIMIT);
   assign w_mreq_val  = w_run && w_credit && (!r_is_write || bus.wdata_val);
   assign w_mreq_fire = w_mreq_val && bus.mreq_rdy;
   assign w_addr      = r_base + r_issued[ADDR_W-1:0];

   assign w_resp_active = bus.mresp_val && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
   assign w_enq_val     = w_resp_active && (bus.mresp_msg.msg_type == ME_TYPE_READ);
   assign w_resp_count  = w_resp_active && (!w_enq_val || w_enq_rdy);

   assign bus.job_rdy   = (r_state == ST_IDLE);
   assign bus.done_val  = (r_state == ST_DONE);
   assign bus.mresp_rdy = 1'b1;
   assign bus.err       = r_err;
   assign bus.mreq_val  = w_mreq_val;
   assign bus.wdata_rdy = w_run && r_is_write && w_credit && bus.mreq_rdy;
   assign bus.mreq_msg  = '{msg_type: (r_is_write ? ME_TYPE_WRITE : ME_TYPE_READ),
                            addr:     w_addr,
                            data:     (r_is_write ? bus.wdata_msg : '0)};

   me_resp_queue #(
      .DATA_W (DATA_W),
      .DEPTH  (MAX_OUTSTANDING)
   ) u_resp_queue (
      .clk       (clk),
      .reset     (reset),
      .i_enq_val (w_enq_val),
      .o_enq_rdy (w_enq_rdy),
      .i_enq_msg (bus.mresp_msg.data),
      .o_deq_val (bus.rdata_val),
      .i_deq_rdy (bus.rdata_rdy),
      .o_deq_msg (bus.rdata_msg),
      .o_count   (w_fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_is_write <= 1'b0;
         r_base     <= '0;
         r_len      <= '0;
         r_issued   <= '0;
         r_received <= '0;
         r_err      <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && bus.mresp_val) begin
            r_err <= 1'b1;
         end
         if (w_resp_count) begin
            r_received <= r_received + c_ONE;
         end
         case (r_state)
            ST_IDLE: begin
               if (bus.job_val) begin
                  r_is_write <= bus.job_msg.is_write;
                  r_base     <= bus.job_msg.base_addr;
                  r_len      <= {1'b0, bus.job_msg.len};
                  r_issued   <= '0;
                  r_received <= '0;
                  r_state    <= (bus.job_msg.len == '0) ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_mreq_fire) begin
                  r_issued <= r_issued + c_ONE;
                  if ((r_issued + c_ONE) == r_len) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if ((r_received == r_len) && (w_fifo_count == '0)) begin
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (bus.done_rdy) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_me_stream_client.sv
`default_nettype none
// ============================================================================
// Module      : tb_me_stream_client
// Description : Randomized bench with a behavioural memory-engine model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_me_stream_client;
   import me_msg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   me_stream_client_if bus();

   me_stream_client dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   bit        k_reset = 1'b1;
   bit        k_job   = 1'b0;
   me_job_msg k_job_msg;
   int        k_mreq_pct, k_rdata_pct, k_wdata_pct, k_done_pct, k_lat_min, k_lat_max;

   logic [31:0]           mem [128];
   memory_engine_send_msg resp_q[$];
   int                    resp_due[$];
   int                    last_due;
   logic [31:0]           wq[$];

   logic [6:0]  log_addr[$];
   logic [31:0] log_data[$];
   logic        log_type[$];
   int          log_cyc[$];
   logic [31:0] rd_log[$];
   int          done_cnt, acc_cyc, n_issue, n_ret, max_infl;
   bit          job_acc, cur_write;

   task automatic defaults();
      k_mreq_pct = 100; k_rdata_pct = 100; k_wdata_pct = 100; k_done_pct = 100;
      k_lat_min = 1; k_lat_max = 1;
   endtask

   // One clock: drive at negedge, record handshakes just after, engine responds in order.
   task automatic step();
      memory_engine_send_msg r;
      int due;
      @(negedge clk);
      reset         = k_reset;
      bus.job_val   = k_job;
      bus.job_msg   = k_job_msg;
      bus.mreq_rdy  = ($urandom_range(99) < k_mreq_pct);
      bus.rdata_rdy = ($urandom_range(99) < k_rdata_pct);
      bus.done_rdy  = ($urandom_range(99) < k_done_pct);
      if (resp_q.size() > 0 && resp_due[0] <= cyc) begin
         bus.mresp_val = 1'b1;
         bus.mresp_msg = resp_q[0];
      end else begin
         bus.mresp_val = 1'b0;
         bus.mresp_msg = '{msg_type: 1'b0, data: $urandom()};
      end
      if (wq.size() > 0 && $urandom_range(99) < k_wdata_pct) begin
         bus.wdata_val = 1'b1;
         bus.wdata_msg = wq[0];
      end else begin
         bus.wdata_val = 1'b0;
         bus.wdata_msg = $urandom();
      end
      #1;
      if (!k_reset) begin
         if (bus.job_val && bus.job_rdy) begin
            job_acc = 1'b1; k_job = 1'b0; acc_cyc = cyc;
         end
         if (bus.mreq_val && bus.mreq_rdy) begin
            log_addr.push_back(bus.mreq_msg.addr);
            log_data.push_back(bus.mreq_msg.data);
            log_type.push_back(bus.mreq_msg.msg_type);
            log_cyc.push_back(cyc);
            n_issue++;
            if (bus.mreq_msg.msg_type == ME_TYPE_WRITE) begin
               mem[bus.mreq_msg.addr] = bus.mreq_msg.data;
               r = '{msg_type: ME_TYPE_WRITE, data: 32'h0};
            end else begin
               r = '{msg_type: ME_TYPE_READ, data: mem[bus.mreq_msg.addr]};
            end
            due = cyc + $urandom_range(k_lat_max, k_lat_min);
            if (due < last_due) due = last_due;
            last_due = due;
            resp_q.push_back(r);
            resp_due.push_back(due);
         end
         if (bus.wdata_val && bus.wdata_rdy) void'(wq.pop_front());
         if (bus.mresp_val && bus.mresp_rdy) begin
            void'(resp_q.pop_front());
            void'(resp_due.pop_front());
            if (cur_write) n_ret++;
         end
         if (bus.rdata_val && bus.rdata_rdy) begin
            rd_log.push_back(bus.rdata_msg);
            if (!cur_write) n_ret++;
         end
         if (bus.done_val && bus.done_rdy) done_cnt++;
         if (n_issue - n_ret > max_infl) max_infl = n_issue - n_ret;
      end
      @(posedge clk);
      cyc++;
   endtask

   task automatic start_job(input bit w, input logic [6:0] base, input logic [7:0] len);
      log_addr.delete(); log_data.delete(); log_type.delete(); log_cyc.delete(); rd_log.delete();
      done_cnt = 0; n_issue = 0; n_ret = 0; max_infl = 0; job_acc = 1'b0; cur_write = w;
      k_job_msg = '{is_write: w, base_addr: base, len: len};
      k_job = 1'b1;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         step();
         if (done_cnt > 0) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      k_reset = 1'b1;
      step(); step();
      #2;
      checks++;
      if ({bus.job_rdy, bus.mreq_val, bus.rdata_val, bus.done_val, bus.wdata_rdy} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_outputs: got rdy/mreq/rdata/done/wrdy=%b want 10000",
                  {bus.job_rdy, bus.mreq_val, bus.rdata_val, bus.done_val, bus.wdata_rdy});
      end
      checks++;
      if (bus.err !== 1'b0) begin
         errors++; $display("FAIL reset_err: got %b want 0", bus.err);
      end
      k_reset = 1'b0;
      step();
   endtask

   task automatic test_read_basic();
      bit ok; int bad;
      for (int i = 0; i < 4; i++) mem[16+i] = 32'hA0 + i;
      defaults();
      start_job(1'b0, 7'h10, 8'd4);
      wait_done(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL read_basic_done: timeout, got done=%0d want 1", done_cnt); end
      bad = -1;
      for (int i = 0; i < log_addr.size(); i++)
         if (bad < 0 && (log_addr[i] !== 7'(16 + i) || log_type[i] !== ME_TYPE_READ || log_data[i] !== 32'h0)) bad = i;
      checks++;
      if (log_addr.size() != 4 || bad >= 0) begin
         errors++; $display("FAIL read_basic_req: got %0d reqs (bad idx %0d) want 4 reads at 0x10..0x13", log_addr.size(), bad);
      end
      checks++;
      if (log_cyc.size() != 4 || log_cyc[3] - log_cyc[0] != 3 || log_cyc[0] != acc_cyc + 1) begin
         errors++; $display("FAIL read_basic_timing: got %0d reqs, not issued back-to-back right after accept", log_cyc.size());
      end
      bad = -1;
      for (int i = 0; i < rd_log.size(); i++) if (bad < 0 && rd_log[i] !== 32'hA0 + i) bad = i;
      checks++;
      if (rd_log.size() != 4 || bad >= 0) begin
         errors++; $display("FAIL read_basic_rdata: got %0d words (bad idx %0d) want A0..A3", rd_log.size(), bad);
      end
      step(); step(); step();
      checks++;
      if (done_cnt != 1) begin errors++; $display("FAIL read_basic_done_once: got %0d want 1", done_cnt); end
   endtask

   task automatic test_write_wrap();
      bit ok; int bad;
      defaults();
      wq = '{32'd1, 32'd2, 32'd3};
      start_job(1'b1, 7'h7E, 8'd3);
      wait_done(200, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL write_wrap_done: timeout, got done=%0d want 1", done_cnt); end
      bad = -1;
      for (int i = 0; i < log_addr.size(); i++)
         if (bad < 0 && (log_addr[i] !== 7'((126 + i) % 128) || log_data[i] !== 32'(i + 1) || log_type[i] !== ME_TYPE_WRITE)) bad = i;
      checks++;
      if (log_addr.size() != 3 || bad >= 0) begin
         errors++; $display("FAIL write_wrap_req: got %0d reqs (bad idx %0d) want 7E/7F/00 with 1/2/3", log_addr.size(), bad);
      end
      checks++;
      if (rd_log.size() != 0) begin errors++; $display("FAIL write_wrap_rdata: got %0d read words want 0", rd_log.size()); end
   endtask

   task automatic test_backpressure();
      bit ok; int bad; logic [31:0] exp_d[$];
      defaults();
      for (int i = 0; i < 8; i++) begin mem[32+i] = $urandom(); exp_d.push_back(mem[32+i]); end
      k_rdata_pct = 0;
      start_job(1'b0, 7'h20, 8'd8);
      for (int i = 0; i < 20; i++) step();
      #2;
      checks++;
      if (n_issue != 4 || bus.mreq_val !== 1'b0) begin
         errors++; $display("FAIL bp_stall: got %0d fires mreq_val=%b want 4 fires mreq_val=0", n_issue, bus.mreq_val);
      end
      k_rdata_pct = 100;
      wait_done(300, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_done: timeout after release, issued %0d", n_issue); end
      bad = -1;
      for (int i = 0; i < rd_log.size(); i++) if (bad < 0 && rd_log[i] !== exp_d[i]) bad = i;
      checks++;
      if (rd_log.size() != 8 || bad >= 0) begin
         errors++; $display("FAIL bp_rdata: got %0d words (bad idx %0d) want 8 matching memory", rd_log.size(), bad);
      end
      checks++;
      if (max_infl > 4) begin errors++; $display("FAIL bp_credit: got max outstanding %0d want <= 4", max_infl); end
   endtask

   task automatic test_len_zero();
      bit seen, held;
      defaults();
      k_done_pct = 0;
      start_job(1'b0, 7'($urandom()), 8'd0);
      for (int i = 0; i < 10 && !job_acc; i++) step();
      seen = 1'b0;
      #2; if (bus.done_val) seen = 1'b1;
      step();
      #2; if (bus.done_val) seen = 1'b1;
      checks++;
      if (!seen) begin errors++; $display("FAIL len0_done: got done_val=%b want 1 within 2 cycles", bus.done_val); end
      held = 1'b1;
      for (int i = 0; i < 3; i++) begin step(); #2; if (bus.done_val !== 1'b1) held = 1'b0; end
      checks++;
      if (!held) begin errors++; $display("FAIL len0_hold: got done_val dropped want held while done_rdy=0"); end
      checks++;
      if (n_issue != 0) begin errors++; $display("FAIL len0_noreq: got %0d requests want 0", n_issue); end
      k_done_pct = 100;
      for (int i = 0; i < 10 && done_cnt == 0; i++) step();
      #2;
      checks++;
      if (done_cnt != 1 || bus.job_rdy !== 1'b1) begin
         errors++; $display("FAIL len0_release: got done=%0d job_rdy=%b want 1/1", done_cnt, bus.job_rdy);
      end
   endtask

   task automatic test_reset_midjob();
      defaults();
      k_lat_min = 50; k_lat_max = 50;
      start_job(1'b0, 7'h40, 8'd6);
      for (int i = 0; i < 20 && n_issue < 2; i++) step();
      k_mreq_pct = 0;
      k_reset = 1'b1;
      step();
      #2;
      checks++;
      if ({bus.job_rdy, bus.mreq_val, bus.rdata_val, bus.done_val, bus.wdata_rdy, bus.err} !== 6'b100000) begin
         errors++; $display("FAIL midjob_reset: got rdy/mreq/rdata/done/wrdy/err=%b want 100000",
                            {bus.job_rdy, bus.mreq_val, bus.rdata_val, bus.done_val, bus.wdata_rdy, bus.err});
      end
      k_reset = 1'b0;
      resp_q.delete(); resp_due.delete(); last_due = 0;
      defaults();
      step();
      #2;
      checks++;
      if (bus.job_rdy !== 1'b1 || bus.rdata_val !== 1'b0) begin
         errors++; $display("FAIL midjob_idle: got job_rdy=%b rdata_val=%b want 1/0", bus.job_rdy, bus.rdata_val);
      end
   endtask

   task automatic test_err_sticky();
      bit ok; int bad; logic [31:0] exp_d[$]; logic [6:0] base;
      defaults();
      resp_q.push_back('{msg_type: ME_TYPE_READ, data: 32'hDEAD});
      resp_due.push_back(0);
      step(); step();
      #2;
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", bus.err); end
      base = 7'($urandom());
      for (int i = 0; i < 5; i++) exp_d.push_back(mem[(int'(base) + i) % 128]);
      start_job(1'b0, base, 8'd5);
      wait_done(200, ok);
      bad = -1;
      for (int i = 0; i < rd_log.size(); i++) if (bad < 0 && rd_log[i] !== exp_d[i]) bad = i;
      checks++;
      if (!ok || rd_log.size() != 5 || bad >= 0) begin
         errors++; $display("FAIL err_job: got done=%0d words=%0d bad idx %0d want clean 5-word read", done_cnt, rd_log.size(), bad);
      end
      #2;
      checks++;
      if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", bus.err); end
      k_reset = 1'b1; step(); k_reset = 1'b0; step();
      #2;
      checks++;
      if (bus.err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", bus.err); end
   endtask

   task automatic test_random_jobs();
      bit ok, w; int bad, len; logic [6:0] base;
      logic [6:0] exp_a[$]; logic [31:0] exp_d[$];
      for (int j = 0; j < 12; j++) begin
         k_mreq_pct  = $urandom_range(100, 30);
         k_rdata_pct = $urandom_range(100, 30);
         k_wdata_pct = $urandom_range(100, 30);
         k_done_pct  = $urandom_range(100, 30);
         k_lat_min = 1; k_lat_max = $urandom_range(4, 1);
         w = 1'($urandom());
         base = 7'($urandom());
         len = $urandom_range(24, 1);
         exp_a.delete(); exp_d.delete(); wq.delete();
         for (int i = 0; i < len; i++) begin
            exp_a.push_back(7'((int'(base) + i) % 128));
            if (w) begin exp_d.push_back($urandom()); wq.push_back(exp_d[i]); end
            else exp_d.push_back(mem[(int'(base) + i) % 128]);
         end
         start_job(w, base, 8'(len));
         wait_done(3000, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL rand_done[%0d]: timeout, issued %0d of %0d", j, n_issue, len); end
         bad = -1;
         for (int i = 0; i < log_addr.size(); i++)
            if (bad < 0 && (log_addr[i] !== exp_a[i] || log_type[i] !== w ||
                            log_data[i] !== (w ? exp_d[i] : 32'h0))) bad = i;
         checks++;
         if (log_addr.size() != len || bad >= 0) begin
            errors++; $display("FAIL rand_req[%0d]: got %0d reqs (bad idx %0d) want %0d", j, log_addr.size(), bad, len);
         end
         bad = -1;
         for (int i = 0; i < rd_log.size(); i++) if (bad < 0 && (w || rd_log[i] !== exp_d[i])) bad = i;
         checks++;
         if (rd_log.size() != (w ? 0 : len) || bad >= 0) begin
            errors++; $display("FAIL rand_rdata[%0d]: got %0d words (bad idx %0d) want %0d", j, rd_log.size(), bad, w ? 0 : len);
         end
         checks++;
         if (max_infl > 4) begin errors++; $display("FAIL rand_credit[%0d]: got max outstanding %0d want <= 4", j, max_infl); end
      end
      defaults();
   endtask

   initial begin
      reset = 1'b1;
      bus.job_val = 1'b0; bus.job_msg = '0; bus.wdata_val = 1'b0; bus.wdata_msg = '0;
      bus.rdata_rdy = 1'b0; bus.mreq_rdy = 1'b0; bus.mresp_val = 1'b0; bus.mresp_msg = '0;
      bus.done_rdy = 1'b0;
      k_job_msg = '0;
      last_due = 0;
      for (int i = 0; i < 128; i++) mem[i] = $urandom();
      defaults();
      test_reset();
      test_read_basic();
      test_write_wrap();
      test_backpressure();
      test_len_zero();
      test_reset_midjob();
      test_err_sticky();
      test_random_jobs();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
